mem_port_arbiter: RTL and testbench

- Shares the single-port instruction/data memory between the fetch stage and the load/store stage.
- Decides which requester gets the memory port each cycle and drives that memory's write and read address/data ports.
- Returns registered read data and acknowledges to each requester.
- Data accesses have priority; a starvation counter guarantees fetch progress.

---
 rtl/mem_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port memory between the fetch stage and the load/store
//   stage. Data requests win by default. A fetch request that keeps losing is
//   counted, and once it has been denied MAX_WAIT times in a row it wins the
//   next contended cycle. Read data and write-acks return one cycle after the
//   grant as single-cycle rvalid pulses. The rdata registers hold their value
//   until that requester's next response.
//
//   Optional feature, enabled by defining MEM_ADDR_CHECK_EN:
//     A granted access is flagged as illegal if it is misaligned or lies beyond
//     MEM_WORDS. An illegal access is still granted, but its write is
//     suppressed. Its response carries err=1 and rdata=0. When the macro is not
//     defined, no check is made, both err outputs stay 0, and the addresses go
//     to the memory unchanged.
//
//   Ports
//     i_clk, i_reset            clock and asynchronous active-low reset
//     i_if_* / o_if_*           fetch requester: req/addr in; gnt/rvalid/rdata/err out
//     i_d_* / o_d_*             data requester: req/we/addr/wdata in; gnt/rvalid/rdata/err out
//     o_mem_* / i_mem_readdata  memory write port, read address and combinational read data
module mem_port_arbiter #(
  parameter int unsigned MAX_WAIT  = 4,
  parameter int unsigned MEM_WORDS = 256
) (
  input  logic        i_clk,
  input  logic        i_reset,
  // fetch requester
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic        o_if_gnt,
  output logic        o_if_rvalid,
  output logic [31:0] o_if_rdata,
  output logic        o_if_err,
  // data requester
  input  logic        i_d_req,
  input  logic        i_d_we,
  input  logic [31:0] i_d_addr,
  input  logic [31:0] i_d_wdata,
  output logic        o_d_gnt,
  output logic        o_d_rvalid,
  output logic [31:0] o_d_rdata,
  output logic        o_d_err,
  // memory port
  output logic [31:0] o_mem_writeaddr,
  output logic [31:0] o_mem_writedata,
  output logic        o_mem_writeenable,
  output logic [31:0] o_mem_readaddr,
  input  logic [31:0] i_mem_readdata
);

  if ((MAX_WAIT < 1) || (MAX_WAIT > 15) || (MEM_WORDS < 1)) begin : g_param_check
    $error("mem_port_arbiter: MAX_WAIT must be 1..15 and MEM_WORDS non-zero");
  end

  localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

  logic [3:0]  r_fetch_wait;
  logic [3:0]  w_fetch_wait_d;
  logic        w_fetch_due;
  logic        w_if_gnt;
  logic        w_d_gnt;
  logic        w_if_bad;
  logic        w_d_bad;

  logic        r_if_rvalid;
  logic [31:0] r_if_rdata;
  logic        r_if_err;
  logic        r_d_rvalid;
  logic [31:0] r_d_rdata;
  logic        r_d_err;

`ifdef MEM_ADDR_CHECK_EN
  function automatic logic addr_bad(input logic [31:0] addr);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= 32'(MEM_WORDS));
  endfunction

  assign w_if_bad = addr_bad(i_if_addr);
  assign w_d_bad  = addr_bad(i_d_addr);
`else
  assign w_if_bad = 1'b0;
  assign w_d_bad  = 1'b0;
`endif

  assign w_fetch_due = (r_fetch_wait == LP_MAX_WAIT);

  // Grants are forced low while reset is asserted, so no access can start
  // (and no write can reach the memory) during reset.
  always_comb begin
    w_if_gnt = 1'b0;
    w_d_gnt  = 1'b0;
    if (i_reset) begin
      if (i_d_req && !(i_if_req && w_fetch_due)) begin
        w_d_gnt = 1'b1;
      end else if (i_if_req) begin
        w_if_gnt = 1'b1;
      end
    end
  end

  // Counts consecutive denied fetch cycles, saturating at MAX_WAIT. A grant
  // or a withdrawn request restarts the count.
  always_comb begin
    w_fetch_wait_d = 4'd0;
    if (i_if_req && !w_if_gnt) begin
      w_fetch_wait_d = w_fetch_due ? r_fetch_wait : r_fetch_wait + 4'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_fetch_wait <= 4'd0;
      r_if_rvalid  <= 1'b0;
      r_if_rdata   <= 32'd0;
      r_if_err     <= 1'b0;
      r_d_rvalid   <= 1'b0;
      r_d_rdata    <= 32'd0;
      r_d_err      <= 1'b0;
    end else begin
      r_fetch_wait <= w_fetch_wait_d;
      r_if_rvalid  <= w_if_gnt;
      r_if_err     <= w_if_gnt && w_if_bad;
      r_d_rvalid   <= w_d_gnt;
      r_d_err      <= w_d_gnt && w_d_bad;
      if (w_if_gnt) begin
        r_if_rdata <= w_if_bad ? 32'd0 : i_mem_readdata;
      end
      // A write-ack returns zero data rather than whatever the read port showed.
      if (w_d_gnt) begin
        r_d_rdata <= (w_d_bad || i_d_we) ? 32'd0 : i_mem_readdata;
      end
    end
  end

  assign o_if_gnt          = w_if_gnt;
  assign o_d_gnt           = w_d_gnt;
  assign o_mem_readaddr    = w_if_gnt ? i_if_addr : i_d_addr;
  assign o_mem_writeaddr   = i_d_addr;
  assign o_mem_writedata   = i_d_wdata;
  assign o_mem_writeenable = w_d_gnt && i_d_we && !w_d_bad;

  assign o_if_rvalid = r_if_rvalid;
  assign o_if_rdata  = r_if_rdata;
  assign o_if_err    = r_if_err;
  assign o_d_rvalid  = r_d_rvalid;
  assign o_d_rdata   = r_d_rdata;
  assign o_d_err     = r_d_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. A 256-word memory lives in the
// bench and is written only by the DUT's write port. A separate shadow copy,
// m_mem, is updated by the reference model, so lost or spurious writes show up
// as read-data differences.
module tb_mem_port_arbiter;

  localparam int unsigned MAX_WAIT  = 4;
  localparam int unsigned MEM_WORDS = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_gnt, if_rvalid, if_err;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [31:0] mem_writeaddr, mem_writedata, mem_readaddr, mem_readdata;
  logic        mem_writeenable;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .MAX_WAIT (MAX_WAIT),
    .MEM_WORDS(MEM_WORDS)
  ) dut (
    .i_clk            (clk),
    .i_reset          (reset),
    .i_if_req         (if_req),
    .i_if_addr        (if_addr),
    .o_if_gnt         (if_gnt),
    .o_if_rvalid      (if_rvalid),
    .o_if_rdata       (if_rdata),
    .o_if_err         (if_err),
    .i_d_req          (d_req),
    .i_d_we           (d_we),
    .i_d_addr         (d_addr),
    .i_d_wdata        (d_wdata),
    .o_d_gnt          (d_gnt),
    .o_d_rvalid       (d_rvalid),
    .o_d_rdata        (d_rdata),
    .o_d_err          (d_err),
    .o_mem_writeaddr  (mem_writeaddr),
    .o_mem_writedata  (mem_writedata),
    .o_mem_writeenable(mem_writeenable),
    .o_mem_readaddr   (mem_readaddr),
    .i_mem_readdata   (mem_readdata)
  );

  // Memory attached to the DUT
  logic [31:0] ram [256];
  logic        init_ram;

  function automatic logic [31:0] init_val(input int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'h0123_4567;
  endfunction

  assign mem_readdata = ram[mem_readaddr[9:2]];

  always @(posedge clk) begin
    if (init_ram) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
    end else if (mem_writeenable) begin
      ram[mem_writeaddr[9:2]] <= mem_writedata;
    end
  end

  // Reference model state
  logic [31:0] m_mem [256];
  int unsigned m_wait;
  bit          e_if_rv, e_if_err, e_d_rv, e_d_err;
  logic [31:0] e_if_rd, e_d_rd;
  int          n_checks = 0;
  int          n_pass   = 0;

  function automatic bit illegal(input logic [31:0] a);
`ifdef MEM_ADDR_CHECK_EN
    return ((a % 4) != 0) || ((a / 4) >= MEM_WORDS);
`else
    return (a === 32'hx);
`endif
  endfunction

  // Data wins unless fetch has already been turned away MAX_WAIT times running.
  function automatic void model_arb(input bit ireq, input bit dreq, output bit eg_if,
                                    output bit eg_d);
    eg_if = ireq && (!dreq || (m_wait >= MAX_WAIT));
    eg_d  = dreq && !eg_if;
  endfunction

  task automatic model_edge(input bit ireq, input logic [31:0] iaddr, input bit dreq,
                            input bit dwe, input logic [31:0] daddr,
                            input logic [31:0] dwdata);
    bit eg_if, eg_d;
    model_arb(ireq, dreq, eg_if, eg_d);
    if (ireq && !eg_if) m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
    else m_wait = 0;
    e_if_rv  = eg_if;
    e_if_err = eg_if && illegal(iaddr);
    if (eg_if) e_if_rd = illegal(iaddr) ? 32'd0 : m_mem[iaddr[9:2]];
    e_d_rv  = eg_d;
    e_d_err = eg_d && illegal(daddr);
    if (eg_d) begin
      if (illegal(daddr)) begin
        e_d_rd = 32'd0;
      end else if (dwe) begin
        m_mem[daddr[9:2]] = dwdata;
        e_d_rd = 32'd0;
      end else begin
        e_d_rd = m_mem[daddr[9:2]];
      end
    end
  endtask

  task automatic model_reset();
    m_wait = 0;
    e_if_rv = 0; e_if_err = 0; e_if_rd = 32'd0;
    e_d_rv = 0;  e_d_err = 0;  e_d_rd = 32'd0;
  endtask

  // Drives one cycle starting at posedge+1. Grants are sampled at the negedge,
  // and the task returns at the next posedge+1.
  task automatic do_cycle(input bit ireq, input logic [31:0] iaddr, input bit dreq,
                          input bit dwe, input logic [31:0] daddr,
                          input logic [31:0] dwdata, output logic g_if, output logic g_d,
                          output logic g_we, output logic [31:0] g_raddr);
    if_req = ireq; if_addr = iaddr;
    d_req = dreq; d_we = dwe; d_addr = daddr; d_wdata = dwdata;
    @(negedge clk);
    g_if = if_gnt; g_d = d_gnt; g_we = mem_writeenable; g_raddr = mem_readaddr;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; init_ram = 1'b1;
    if_req = 1'b1; if_addr = 32'h8; d_req = 1'b1; d_we = 1'b1;
    d_addr = 32'h10; d_wdata = 32'h1111_2222;
    for (int i = 0; i < 256; i++) m_mem[i] = init_val(i);
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    init_ram = 1'b0;
    n_checks++; if (if_gnt !== 1'b0) $display("FAIL rst_if_gnt: got %b exp 0", if_gnt);
    else n_pass++;
    n_checks++; if (d_gnt !== 1'b0) $display("FAIL rst_d_gnt: got %b exp 0", d_gnt);
    else n_pass++;
    n_checks++; if (mem_writeenable !== 1'b0) $display("FAIL rst_we: got %b exp 0",
                                                       mem_writeenable);
    else n_pass++;
    n_checks++; if ({if_rvalid, d_rvalid, if_err, d_err} !== 4'b0)
      $display("FAIL rst_flags: got %b exp 0000", {if_rvalid, d_rvalid, if_err, d_err});
    else n_pass++;
    n_checks++; if ({if_rdata, d_rdata} !== 64'd0)
      $display("FAIL rst_rdata: got %h/%h exp 0/0", if_rdata, d_rdata);
    else n_pass++;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (ram[4] !== m_mem[4]) $display("FAIL rst_nowrite: got %h exp %h",
                                                  ram[4], m_mem[4]);
    else n_pass++;
  endtask

  task automatic test_fetch_only();
    logic g_if, g_d, g_we;
    logic [31:0] ra, a;
    for (int k = 0; k < 3; k++) begin
      a = 32'h8 + 32'(4 * k);
      do_cycle(1, a, 0, 0, 32'h0, 32'h0, g_if, g_d, g_we, ra);
      model_edge(1, a, 0, 0, 32'h0, 32'h0);
      n_checks++; if (g_if !== 1'b1) $display("FAIL fetch_gnt k%0d: got %b exp 1", k, g_if);
      else n_pass++;
      n_checks++; if (if_rvalid !== 1'b1) $display("FAIL fetch_rv k%0d: got %b exp 1", k,
                                                   if_rvalid);
      else n_pass++;
      n_checks++; if (if_rdata !== init_val(2 + k))
        $display("FAIL fetch_rdata k%0d: got %h exp %h", k, if_rdata, init_val(2 + k));
      else n_pass++;
    end
    do_cycle(0, 32'h0, 0, 0, 32'h0, 32'h0, g_if, g_d, g_we, ra);
    model_edge(0, 32'h0, 0, 0, 32'h0, 32'h0);
    n_checks++; if (if_rvalid !== 1'b0 || if_rdata !== init_val(4))
      $display("FAIL fetch_hold: got %b/%h exp 0/%h", if_rvalid, if_rdata, init_val(4));
    else n_pass++;
  endtask

  task automatic test_write_read();
    logic g_if, g_d, g_we;
    logic [31:0] ra;
    do_cycle(0, 32'h0, 1, 0, 32'h50, 32'h0, g_if, g_d, g_we, ra);
    model_edge(0, 32'h0, 1, 0, 32'h50, 32'h0);
    n_checks++; if (d_rdata !== init_val(20)) $display("FAIL wr_pre: got %h exp %h",
                                                       d_rdata, init_val(20));
    else n_pass++;
    do_cycle(0, 32'h0, 1, 1, 32'h40, 32'hDEAD_BEEF, g_if, g_d, g_we, ra);
    model_edge(0, 32'h0, 1, 1, 32'h40, 32'hDEAD_BEEF);
    n_checks++; if ({g_d, g_we} !== 2'b11) $display("FAIL wr_gnt_we: got %b exp 11",
                                                    {g_d, g_we});
    else n_pass++;
    n_checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'd0)
      $display("FAIL wr_ack: got %b/%h exp 1/0", d_rvalid, d_rdata);
    else n_pass++;
    do_cycle(0, 32'h0, 1, 0, 32'h40, 32'h0, g_if, g_d, g_we, ra);
    model_edge(0, 32'h0, 1, 0, 32'h40, 32'h0);
    n_checks++; if ({g_d, g_we} !== 2'b10) $display("FAIL rd_gnt_we: got %b exp 10",
                                                    {g_d, g_we});
    else n_pass++;
    n_checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'hDEAD_BEEF)
      $display("FAIL rd_back: got %b/%h exp 1/deadbeef", d_rvalid, d_rdata);
    else n_pass++;
  endtask

  // Both requesters held for n cycles; fetch must win every (MAX_WAIT+1)th one.
  task automatic test_starvation(input int n);
    logic g_if, g_d, g_we;
    logic [31:0] ra;
    bit exp_if;
    for (int k = 0; k < n; k++) begin
      exp_if = ((k + 1) % (MAX_WAIT + 1)) == 0;
      do_cycle(1, 32'h20, 1, 0, 32'h30, 32'h0, g_if, g_d, g_we, ra);
      model_edge(1, 32'h20, 1, 0, 32'h30, 32'h0);
      n_checks++; if ({g_if, g_d} !== {exp_if, !exp_if})
        $display("FAIL starve k%0d: got if/d %b%b exp %b%b", k, g_if, g_d, exp_if, !exp_if);
      else n_pass++;
      n_checks++; if ({if_rvalid, d_rvalid} !== {exp_if, !exp_if})
        $display("FAIL starve_rv k%0d: got %b%b exp %b%b", k, if_rvalid, d_rvalid,
                 exp_if, !exp_if);
      else n_pass++;
    end
  endtask

  task automatic test_withdraw();
    logic g_if, g_d, g_we;
    logic [31:0] ra;
    do_cycle(1, 32'h24, 1, 0, 32'h34, 32'h0, g_if, g_d, g_we, ra);
    model_edge(1, 32'h24, 1, 0, 32'h34, 32'h0);
    n_checks++; if ({g_if, g_d} !== 2'b01) $display("FAIL wd_gnt: got %b%b exp 01", g_if, g_d);
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      do_cycle(0, 32'h24, 0, 0, 32'h0, 32'h0, g_if, g_d, g_we, ra);
      model_edge(0, 32'h24, 0, 0, 32'h0, 32'h0);
      n_checks++; if (if_rvalid !== 1'b0) $display("FAIL wd_rv k%0d: got %b exp 0", k,
                                                   if_rvalid);
      else n_pass++;
    end
    // A stale wait count would let fetch win before the MAX_WAIT+1th cycle.
    test_starvation(MAX_WAIT + 1);
  endtask

  task automatic test_reset_mid();
    logic g_if, g_d, g_we;
    logic [31:0] ra;
    do_cycle(1, 32'h18, 0, 0, 32'h0, 32'h0, g_if, g_d, g_we, ra);
    model_edge(1, 32'h18, 0, 0, 32'h0, 32'h0);
    do_cycle(0, 32'h0, 1, 0, 32'h14, 32'h0, g_if, g_d, g_we, ra);
    model_edge(0, 32'h0, 1, 0, 32'h14, 32'h0);
    n_checks++; if (d_rvalid !== 1'b1 || if_rdata !== m_mem[6] || d_rdata !== m_mem[5])
      $display("FAIL rm_pre: got %b/%h/%h exp 1/%h/%h", d_rvalid, if_rdata, d_rdata,
               m_mem[6], m_mem[5]);
    else n_pass++;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'hA5A5_5A5A;
    @(negedge clk);
    n_checks++; if ({d_gnt, mem_writeenable} !== 2'b11)
      $display("FAIL rm_gnt: got %b exp 11", {d_gnt, mem_writeenable});
    else n_pass++;
    #2 reset = 1'b0;
    #1;
    n_checks++; if ({d_gnt, mem_writeenable, if_rvalid, d_rvalid} !== 4'b0)
      $display("FAIL rm_async: got %b exp 0000", {d_gnt, mem_writeenable, if_rvalid, d_rvalid});
    else n_pass++;
    n_checks++; if ({if_rdata, d_rdata} !== 64'd0)
      $display("FAIL rm_rdata: got %h/%h exp 0/0", if_rdata, d_rdata);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (ram[4] !== m_mem[4]) $display("FAIL rm_nowrite: got %h exp %h",
                                                  ram[4], m_mem[4]);
    else n_pass++;
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clk); reset = 1'b1;
    model_reset();
    @(posedge clk); #1;
  endtask

`ifdef MEM_ADDR_CHECK_EN
  task automatic test_addr_check();
    logic g_if, g_d, g_we;
    logic [31:0] ra;
    do_cycle(0, 32'h0, 1, 1, 32'h402, 32'h1234_5678, g_if, g_d, g_we, ra);
    model_edge(0, 32'h0, 1, 1, 32'h402, 32'h1234_5678);
    n_checks++; if ({g_d, g_we} !== 2'b10) $display("FAIL ac_we: got %b exp 10", {g_d, g_we});
    else n_pass++;
    n_checks++; if ({d_rvalid, d_err} !== 2'b11 || d_rdata !== 32'd0)
      $display("FAIL ac_derr: got %b%b/%h exp 11/0", d_rvalid, d_err, d_rdata);
    else n_pass++;
    n_checks++; if (ram[0] !== m_mem[0]) $display("FAIL ac_mem: got %h exp %h",
                                                  ram[0], m_mem[0]);
    else n_pass++;
    do_cycle(1, 32'h4, 0, 0, 32'h0, 32'h0, g_if, g_d, g_we, ra);
    model_edge(1, 32'h4, 0, 0, 32'h0, 32'h0);
    n_checks++; if (if_err !== 1'b0 || if_rdata !== m_mem[1])
      $display("FAIL ac_ok: got %b/%h exp 0/%h", if_err, if_rdata, m_mem[1]);
    else n_pass++;
    do_cycle(1, 32'h400, 0, 0, 32'h0, 32'h0, g_if, g_d, g_we, ra);
    model_edge(1, 32'h400, 0, 0, 32'h0, 32'h0);
    n_checks++; if ({if_rvalid, if_err} !== 2'b11 || if_rdata !== 32'd0)
      $display("FAIL ac_iferr: got %b%b/%h exp 11/0", if_rvalid, if_err, if_rdata);
    else n_pass++;
  endtask
`else
  task automatic test_addr_check();
    logic g_if, g_d, g_we;
    logic [31:0] ra;
    do_cycle(0, 32'h0, 1, 0, 32'h42, 32'h0, g_if, g_d, g_we, ra);
    model_edge(0, 32'h0, 1, 0, 32'h42, 32'h0);
    n_checks++; if (ra !== 32'h42) $display("FAIL ac_addr: got %h exp 00000042", ra);
    else n_pass++;
    n_checks++; if ({d_rvalid, d_err} !== 2'b10 || d_rdata !== m_mem[16])
      $display("FAIL ac_noerr: got %b%b/%h exp 10/%h", d_rvalid, d_err, d_rdata, m_mem[16]);
    else n_pass++;
  endtask
`endif

  function automatic logic [31:0] rand_addr();
`ifdef MEM_ADDR_CHECK_EN
    if ($urandom_range(0, 9) == 0) return $urandom_range(0, 1) ? 32'($urandom)
                                          : 32'($urandom_range(0, 31) * 4 + 1);
`endif
    return 32'($urandom_range(0, 31)) << 2;
  endfunction

  task automatic test_random(input int n);
    logic g_if, g_d, g_we;
    logic [31:0] ra, exp_ra;
    bit p_if = 0, p_d = 0, p_we = 0, eg_if, eg_d, exp_we;
    logic [31:0] p_ia = 32'h0, p_da = 32'h0, p_wd = 32'h0;
    for (int c = 0; c < n; c++) begin
      if (!p_if) begin
        p_if = $urandom_range(0, 99) < 60; p_ia = rand_addr();
      end else if ($urandom_range(0, 99) < 5) begin
        p_if = 0;
      end
      if (!p_d) begin
        p_d = $urandom_range(0, 99) < 60; p_da = rand_addr();
        p_we = $urandom_range(0, 1) == 1; p_wd = $urandom;
      end else if ($urandom_range(0, 99) < 5) begin
        p_d = 0;
      end
      model_arb(p_if, p_d, eg_if, eg_d);
      exp_ra = eg_if ? p_ia : p_da;
      exp_we = eg_d && p_we && !illegal(p_da);
      do_cycle(p_if, p_ia, p_d, p_we, p_da, p_wd, g_if, g_d, g_we, ra);
      model_edge(p_if, p_ia, p_d, p_we, p_da, p_wd);
      n_checks++; if ({g_if, g_d, g_we} !== {eg_if, eg_d, exp_we})
        $display("FAIL rnd_gnt c%0d: got %b%b%b exp %b%b%b", c, g_if, g_d, g_we,
                 eg_if, eg_d, exp_we);
      else n_pass++;
      n_checks++; if (ra !== exp_ra) $display("FAIL rnd_raddr c%0d: got %h exp %h", c,
                                              ra, exp_ra);
      else n_pass++;
      n_checks++; if ({if_rvalid, d_rvalid} !== {e_if_rv, e_d_rv})
        $display("FAIL rnd_rv c%0d: got %b%b exp %b%b", c, if_rvalid, d_rvalid,
                 e_if_rv, e_d_rv);
      else n_pass++;
      n_checks++; if (if_rdata !== e_if_rd || d_rdata !== e_d_rd)
        $display("FAIL rnd_rdata c%0d: got %h/%h exp %h/%h", c, if_rdata, d_rdata,
                 e_if_rd, e_d_rd);
      else n_pass++;
      if (e_if_rv || e_d_rv) begin
        n_checks++; if ((e_if_rv && if_err !== e_if_err) || (e_d_rv && d_err !== e_d_err))
          $display("FAIL rnd_err c%0d: got %b%b exp %b%b", c, if_err, d_err,
                   e_if_err, e_d_err);
        else n_pass++;
      end
      if (eg_if) p_if = 0;
      if (eg_d) p_d = 0;
    end
  endtask

  task automatic test_mem_image();
    int bad = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== m_mem[i]) bad++;
    n_checks++; if (bad != 0) $display("FAIL mem_image: got %0d differing words exp 0", bad);
    else n_pass++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fetch_only();
    test_write_read();
    test_starvation(10);
    test_withdraw();
    test_reset_mid();
    test_addr_check();
    test_random(400);
    test_mem_image();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
